// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared state encoding, defaults and round-robin search for rr_mux_arbiter
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    localparam int DEF_N         = 4;
    localparam int DEF_W         = 8;
    localparam int DEF_MAX_BURST = 4;
    localparam int MAX_N         = 16;

    // Index of the first set bit of req[n-1:0] visiting ptr, ptr+1, ... modulo n.
    // When nothing is set the pointer itself comes back; callers qualify with |req.
    function automatic logic [3:0] rr_first(input logic [MAX_N-1:0] req,
                                            input logic [3:0]       ptr,
                                            input int               n);
        logic [3:0] idx;
        logic [3:0] pick;
        pick = ptr;
        // walk from the farthest offset down so the nearest hit is the one kept
        for (int i = MAX_N - 1; i >= 0; i--) begin
            idx = 4'((int'(ptr) + i) % n);
            if (i < n && req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_sel_tree.sv
// rtl/rr_sel_tree.sv - log2(N)-level tree of 2:1 muxes selecting one requester word by sel
module mux2x1 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         s,
    output logic [W-1:0] y
);

    assign y = s ? b : a;

endmodule

module rr_sel_tree
    import rr_arb_pkg::*;
#(
    parameter  int N  = DEF_N,
    parameter  int W  = DEF_W,
    localparam int SW = $clog2(N)
) (
    input  logic [N*W-1:0] data_in,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   data_out
);

    // Heap-ordered nodes: node 1 is the root, node k has children 2k and 2k+1,
    // leaves sit at N..2N-1 so leaf N+i carries requester i.
    logic [W-1:0] node [1:2*N-1];

    for (genvar i = 0; i < N; i++) begin : g_leaf
        assign node[N+i] = data_in[i*W +: W];
    end

    // A node at depth d steers on select bit SW-1-d, so the leaves use sel[0].
    for (genvar k = 1; k < N; k++) begin : g_node
        localparam int D = $clog2(k + 1) - 1;
        mux2x1 #(.W(W)) u_mux (
            .a (node[2*k]),
            .b (node[2*k+1]),
            .s (sel[SW-1-D]),
            .y (node[k])
        );
    end

    assign data_out = node[1];

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin locking arbiter and registered mux channel; RR_BURST_LIMIT_EN caps bursts at MAX_BURST
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int N         = DEF_N,
    parameter  int W         = DEF_W,
    parameter  int MAX_BURST = DEF_MAX_BURST,
    localparam int SW        = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] data_in,
    output logic [N-1:0]   grant,
    output logic [SW-1:0]  sel,
    output logic           out_valid,
    output logic [W-1:0]   out_data
);

    if (N < 2 || N > MAX_N || (N & (N - 1)) != 0 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_params
        $error("rr_mux_arbiter: unsupported N or MAX_BURST");
    end

    localparam logic [N-1:0] ONE = N'(1);

    arb_state_t       state;
    logic [SW-1:0]    ptr;
    logic [SW-1:0]    next_ptr;
    logic [N-1:0]     others;
    logic [MAX_N-1:0] req_ext;
    logic [MAX_N-1:0] others_ext;
    logic [3:0]       idle_idx;
    logic [3:0]       rel_idx;
    logic             req_any;
    logic             rel_any;
    logic             owner_req;
    logic             release_now;
    logic             xfer;
    logic [W-1:0]     tree_out;

    rr_sel_tree #(.N(N), .W(W)) u_tree (
        .data_in  (data_in),
        .sel      (sel),
        .data_out (tree_out)
    );

    // everyone except the current owner, widened to the package search width
    always_comb begin
        others              = req & ~grant;
        req_ext             = '0;
        others_ext          = '0;
        req_ext[N-1:0]      = req;
        others_ext[N-1:0]   = others;
    end

    assign next_ptr  = sel + SW'(1);
    assign idle_idx  = rr_first(req_ext, 4'(ptr), N);
    assign rel_idx   = rr_first(others_ext, 4'(next_ptr), N);
    assign req_any   = |req;
    assign rel_any   = |others;
    assign owner_req = req[sel];
    assign xfer      = (state == OWNED) && owner_req;

`ifdef RR_BURST_LIMIT_EN
    logic [7:0] burst_cnt;
    logic       cap_hit;

    // a full burst only forces a hand-over when someone else is actually waiting
    assign cap_hit     = (burst_cnt == 8'(MAX_BURST));
    assign release_now = !owner_req || (cap_hit && rel_any);

    // burst length of the current owner; a capped owner with no rivals starts a fresh burst
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt <= '0;
        end else if (state == IDLE) begin
            if (req_any) begin
                burst_cnt <= 8'd1;
            end
        end else if (release_now) begin
            if (rel_any) begin
                burst_cnt <= 8'd1;
            end
        end else if (cap_hit) begin
            burst_cnt <= 8'd1;
        end else begin
            burst_cnt <= burst_cnt + 8'd1;
        end
    end
`else
    assign release_now = !owner_req;
`endif

    // arbitration FSM with registered grant/sel and the registered transfer stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            sel       <= '0;
            ptr       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= tree_out;
            end
            case (state)
                IDLE: begin
                    if (req_any) begin
                        state <= OWNED;
                        grant <= ONE << idle_idx;
                        sel   <= idle_idx[SW-1:0];
                    end
                end
                OWNED: begin
                    if (release_now) begin
                        // hand straight to the next requester after the owner, no idle bubble
                        ptr <= next_ptr;
                        if (rel_any) begin
                            grant <= ONE << rel_idx;
                            sel   <= rel_idx[SW-1:0];
                        end else begin
                            state <= IDLE;
                            grant <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
